// File: rtl/glb_weight_ctrl.sv
// glb_weight_ctrl: weight global-buffer sequencer. One start runs a full job:
// load F*K weights from the loader into the GLB, then replay them P times to
// the PE weight bus through a 2-entry skid FIFO.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start, cfg_*          job start and config (F filters, K weights, P passes)
//   ld_valid/ready/data   load stream from the DMA/loader
//   glb_write_en/w_addr/w_data   GLB write port
//   glb_read_req/r_addr/r_data   GLB read port (data one cycle after request)
//   wt_valid/ready/data, wt_last_filt, wt_last   weight stream to PEs
//   busy, done, cfg_error job status
module glb_weight_ctrl #(
    parameter int DATA_BITWIDTH = 16,
    parameter int ADDR_BITWIDTH = 10,
    parameter int CNT_BITWIDTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [CNT_BITWIDTH-1:0]  cfg_num_filters,
    input  logic [CNT_BITWIDTH-1:0]  cfg_filt_size,
    input  logic [CNT_BITWIDTH-1:0]  cfg_num_passes,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [DATA_BITWIDTH-1:0] ld_data,
    output logic                     glb_write_en,
    output logic [ADDR_BITWIDTH-1:0] glb_w_addr,
    output logic [DATA_BITWIDTH-1:0] glb_w_data,
    output logic                     glb_read_req,
    output logic [ADDR_BITWIDTH-1:0] glb_r_addr,
    input  logic [DATA_BITWIDTH-1:0] glb_r_data,
    output logic                     wt_valid,
    input  logic                     wt_ready,
    output logic [DATA_BITWIDTH-1:0] wt_data,
    output logic                     wt_last_filt,
    output logic                     wt_last,
    output logic                     busy,
    output logic                     done,
    output logic                     cfg_error
);

    localparam int PW = 2 * CNT_BITWIDTH;
    localparam logic [PW:0] CAP = {{PW{1'b0}}, 1'b1} << ADDR_BITWIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DISPATCH,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    // Config latched as "minus one" values so end-of-loop tests are equalities.
    logic [CNT_BITWIDTH-1:0]  f_m1_q, f_m1_d;
    logic [CNT_BITWIDTH-1:0]  k_m1_q, k_m1_d;
    logic [CNT_BITWIDTH-1:0]  p_m1_q, p_m1_d;
    logic [PW-1:0]            n_m1_q, n_m1_d;
    logic                     cfg_error_q, cfg_error_d;

    logic [ADDR_BITWIDTH-1:0] wr_cnt_q, wr_cnt_d;

    // Read iteration: k innermost, then f, then pass p.
    logic [CNT_BITWIDTH-1:0]  rk_q, rk_d;
    logic [CNT_BITWIDTH-1:0]  rf_q, rf_d;
    logic [CNT_BITWIDTH-1:0]  rp_q, rp_d;
    logic [ADDR_BITWIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                     rd_done_q, rd_done_d;

    // Tags of the read currently in flight through the GLB.
    logic                     infl_q, infl_d;
    logic                     infl_lf_q, infl_lf_d;
    logic                     infl_ls_q, infl_ls_d;

    // Skid FIFO, entry 0 is the head.
    logic [1:0]               occ_q, occ_d;
    logic [DATA_BITWIDTH-1:0] fd0_q, fd0_d, fd1_q, fd1_d;
    logic                     lf0_q, lf0_d, lf1_q, lf1_d;
    logic                     ls0_q, ls0_d, ls1_q, ls1_d;

    logic [PW-1:0]            prod;
    logic                     cfg_bad;
    logic                     wr_last;
    logic                     pop;
    logic                     push;
    logic                     issue;
    logic                     tag_lf;
    logic                     tag_ls;

    assign prod    = PW'(cfg_num_filters) * PW'(cfg_filt_size);
    assign cfg_bad = (cfg_num_filters == '0) || (cfg_filt_size == '0) ||
                     (cfg_num_passes == '0) || ({1'b0, prod} > CAP);

    assign wr_last = ({{(PW-ADDR_BITWIDTH){1'b0}}, wr_cnt_q} == n_m1_q);

    assign wt_valid = (occ_q != 2'd0);
    assign pop      = wt_valid && wt_ready;
    assign push     = infl_q;

    // Issue only if the word is guaranteed a FIFO slot when it returns.
    assign issue = (state_q == S_DISPATCH) && !rd_done_q &&
                   (({1'b0, occ_q} + {2'b0, infl_q} - {2'b0, pop}) < 3'd2);

    assign tag_lf = (rk_q == k_m1_q);
    assign tag_ls = tag_lf && (rf_q == f_m1_q) && (rp_q == p_m1_q);

    always_comb begin
        state_d     = state_q;
        f_m1_d      = f_m1_q;
        k_m1_d      = k_m1_q;
        p_m1_d      = p_m1_q;
        n_m1_d      = n_m1_q;
        cfg_error_d = cfg_error_q;
        wr_cnt_d    = wr_cnt_q;
        rk_d        = rk_q;
        rf_d        = rf_q;
        rp_d        = rp_q;
        rd_addr_d   = rd_addr_q;
        rd_done_d   = rd_done_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    f_m1_d      = cfg_num_filters - CNT_BITWIDTH'(1);
                    k_m1_d      = cfg_filt_size - CNT_BITWIDTH'(1);
                    p_m1_d      = cfg_num_passes - CNT_BITWIDTH'(1);
                    n_m1_d      = prod - PW'(1);
                    cfg_error_d = cfg_bad;
                    wr_cnt_d    = '0;
                    rk_d        = '0;
                    rf_d        = '0;
                    rp_d        = '0;
                    rd_addr_d   = '0;
                    rd_done_d   = 1'b0;
                    state_d     = cfg_bad ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (ld_valid) begin
                    wr_cnt_d = wr_cnt_q + ADDR_BITWIDTH'(1);
                    if (wr_last) begin
                        state_d = S_DISPATCH;
                    end
                end
            end
            S_DISPATCH: begin
                if (pop && ls0_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (issue) begin
            if (tag_ls) begin
                rd_done_d = 1'b1;
            end
            if (tag_lf) begin
                rk_d = '0;
                if (rf_q == f_m1_q) begin
                    rf_d      = '0;
                    rp_d      = rp_q + CNT_BITWIDTH'(1);
                    rd_addr_d = '0;
                end else begin
                    rf_d      = rf_q + CNT_BITWIDTH'(1);
                    rd_addr_d = rd_addr_q + ADDR_BITWIDTH'(1);
                end
            end else begin
                rk_d      = rk_q + CNT_BITWIDTH'(1);
                rd_addr_d = rd_addr_q + ADDR_BITWIDTH'(1);
            end
        end
    end

    always_comb begin
        infl_d    = issue;
        infl_lf_d = issue ? tag_lf : infl_lf_q;
        infl_ls_d = issue ? tag_ls : infl_ls_q;
        occ_d     = occ_q;
        fd0_d     = fd0_q;
        fd1_d     = fd1_q;
        lf0_d     = lf0_q;
        lf1_d     = lf1_q;
        ls0_d     = ls0_q;
        ls1_d     = ls1_q;

        unique case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    fd0_d = glb_r_data;
                    lf0_d = infl_lf_q;
                    ls0_d = infl_ls_q;
                end else begin
                    fd1_d = glb_r_data;
                    lf1_d = infl_lf_q;
                    ls1_d = infl_ls_q;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                fd0_d = fd1_q;
                lf0_d = lf1_q;
                ls0_d = ls1_q;
                occ_d = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    fd0_d = glb_r_data;
                    lf0_d = infl_lf_q;
                    ls0_d = infl_ls_q;
                end else begin
                    fd0_d = fd1_q;
                    lf0_d = lf1_q;
                    ls0_d = ls1_q;
                    fd1_d = glb_r_data;
                    lf1_d = infl_lf_q;
                    ls1_d = infl_ls_q;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            f_m1_q      <= '0;
            k_m1_q      <= '0;
            p_m1_q      <= '0;
            n_m1_q      <= '0;
            cfg_error_q <= 1'b0;
            wr_cnt_q    <= '0;
            rk_q        <= '0;
            rf_q        <= '0;
            rp_q        <= '0;
            rd_addr_q   <= '0;
            rd_done_q   <= 1'b0;
            infl_q      <= 1'b0;
            infl_lf_q   <= 1'b0;
            infl_ls_q   <= 1'b0;
            occ_q       <= '0;
            fd0_q       <= '0;
            fd1_q       <= '0;
            lf0_q       <= 1'b0;
            lf1_q       <= 1'b0;
            ls0_q       <= 1'b0;
            ls1_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            f_m1_q      <= f_m1_d;
            k_m1_q      <= k_m1_d;
            p_m1_q      <= p_m1_d;
            n_m1_q      <= n_m1_d;
            cfg_error_q <= cfg_error_d;
            wr_cnt_q    <= wr_cnt_d;
            rk_q        <= rk_d;
            rf_q        <= rf_d;
            rp_q        <= rp_d;
            rd_addr_q   <= rd_addr_d;
            rd_done_q   <= rd_done_d;
            infl_q      <= infl_d;
            infl_lf_q   <= infl_lf_d;
            infl_ls_q   <= infl_ls_d;
            occ_q       <= occ_d;
            fd0_q       <= fd0_d;
            fd1_q       <= fd1_d;
            lf0_q       <= lf0_d;
            lf1_q       <= lf1_d;
            ls0_q       <= ls0_d;
            ls1_q       <= ls1_d;
        end
    end

    assign ld_ready     = (state_q == S_LOAD);
    assign glb_write_en = (state_q == S_LOAD) && ld_valid;
    assign glb_w_addr   = wr_cnt_q;
    assign glb_w_data   = ld_data;
    assign glb_read_req = issue;
    assign glb_r_addr   = rd_addr_q;
    assign wt_data      = fd0_q;
    assign wt_last_filt = wt_valid && lf0_q;
    assign wt_last      = wt_valid && ls0_q;
    assign busy         = (state_q == S_LOAD) || (state_q == S_DISPATCH);
    assign done         = (state_q == S_DONE);
    assign cfg_error    = cfg_error_q;

endmodule

// File: tb/tb_glb_weight_ctrl.sv
// Testbench for glb_weight_ctrl: table of jobs with a GLB memory model and a
// reference stream built from nested pass/filter/weight loops.
module tb_glb_weight_ctrl;

    localparam int DW = 16;
    localparam int AW = 10;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [CW-1:0] cfg_num_filters;
    logic [CW-1:0] cfg_filt_size;
    logic [CW-1:0] cfg_num_passes;
    logic          ld_valid;
    logic          ld_ready;
    logic [DW-1:0] ld_data;
    logic          glb_write_en;
    logic [AW-1:0] glb_w_addr;
    logic [DW-1:0] glb_w_data;
    logic          glb_read_req;
    logic [AW-1:0] glb_r_addr;
    logic [DW-1:0] glb_r_data;
    logic          wt_valid;
    logic          wt_ready;
    logic [DW-1:0] wt_data;
    logic          wt_last_filt;
    logic          wt_last;
    logic          busy;
    logic          done;
    logic          cfg_error;

    glb_weight_ctrl #(
        .DATA_BITWIDTH(DW),
        .ADDR_BITWIDTH(AW),
        .CNT_BITWIDTH (CW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .cfg_num_filters(cfg_num_filters),
        .cfg_filt_size  (cfg_filt_size),
        .cfg_num_passes (cfg_num_passes),
        .ld_valid       (ld_valid),
        .ld_ready       (ld_ready),
        .ld_data        (ld_data),
        .glb_write_en   (glb_write_en),
        .glb_w_addr     (glb_w_addr),
        .glb_w_data     (glb_w_data),
        .glb_read_req   (glb_read_req),
        .glb_r_addr     (glb_r_addr),
        .glb_r_data     (glb_r_data),
        .wt_valid       (wt_valid),
        .wt_ready       (wt_ready),
        .wt_data        (wt_data),
        .wt_last_filt   (wt_last_filt),
        .wt_last        (wt_last),
        .busy           (busy),
        .done           (done),
        .cfg_error      (cfg_error)
    );

    always #5 clk = ~clk;

    // GLB model: write committed at the edge, registered 1-cycle read.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (glb_write_en) mem[glb_w_addr] <= glb_w_data;
        if (glb_read_req) glb_r_data <= mem[glb_r_addr];
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input longint act,
                         input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    logic [DW-1:0] ld_words[$];

    typedef struct {
        int f;
        int k;
        int p;
        int rdy_pct;
        int vld_pct;
        bit seq;
        bit poke;
        bit exp_err;
        int exp_words;
    } vec_t;

    vec_t tbl[12];

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ld_ready"}, ld_ready, 0);
        check({tag, "_write_en"}, glb_write_en, 0);
        check({tag, "_read_req"}, glb_read_req, 0);
        check({tag, "_wt_valid"}, wt_valid, 0);
        check({tag, "_last_filt"}, wt_last_filt, 0);
        check({tag, "_wt_last"}, wt_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_cfg_error"}, cfg_error, 0);
        check({tag, "_w_addr"}, glb_w_addr, 0);
        check({tag, "_r_addr"}, glb_r_addr, 0);
        check({tag, "_wt_data"}, wt_data, 0);
    endtask

    task automatic run_job(input string nm, input int f, input int k,
                           input int p, input int rdy_pct, input int vld_pct,
                           input bit poke, input bit exp_err,
                           input int exp_words, input int abort_pops);
        int n;
        int bound;
        int cyc;
        int li = 0;
        int oi = 0;
        int reads = 0;
        int load_cyc = 0;
        int disp_cyc = 0;
        int last_hs = -1;
        int first_rd = -1;
        int dones = 0;
        int both = 0;
        int wr_bad = 0;
        int out_bad = 0;
        int over = 0;
        int stall_bad = 0;
        bit stall = 0;
        logic [DW-1:0] st_d;
        logic st_lf;
        logic st_ls;
        logic [DW-1:0] exp_q[$];
        bit lf_q[$];
        bit ls_q[$];

        n = f * k;
        if (!exp_err) begin
            for (int pp = 0; pp < p; pp++)
                for (int ff = 0; ff < f; ff++)
                    for (int kk = 0; kk < k; kk++) begin
                        exp_q.push_back(ld_words[ff*k+kk]);
                        lf_q.push_back(kk == k-1);
                        ls_q.push_back(pp == p-1 && ff == f-1 && kk == k-1);
                    end
        end
        bound = exp_err ? 10 : 40 * (exp_words + n) + 50;

        @(negedge clk);
        cfg_num_filters = CW'(f);
        cfg_filt_size   = CW'(k);
        cfg_num_passes  = CW'(p);
        start    = 1'b1;
        ld_valid = 1'b0;
        wt_ready = 1'b0;
        #1;
        check({nm, "_idle_at_start"}, {busy, done}, 0);

        for (cyc = 1; cyc <= bound; cyc++) begin
            @(negedge clk);
            start = poke && (cyc == 2 || oi == 2);
            cfg_num_filters = CW'($urandom);
            cfg_filt_size   = CW'($urandom);
            cfg_num_passes  = CW'($urandom);
            ld_valid = (li < n) && ($urandom_range(1, 100) <= vld_pct);
            ld_data  = (li < n) ? ld_words[li] : '0;
            wt_ready = ($urandom_range(1, 100) <= rdy_pct);
            #1;
            if (cyc == 1) begin
                if (exp_err) begin
                    check({nm, "_err_flag"}, cfg_error, 1);
                    check({nm, "_err_done"}, done, 1);
                    check({nm, "_err_busy"}, busy, 0);
                end else begin
                    check({nm, "_busy_t1"}, busy, 1);
                    check({nm, "_ld_ready_t1"}, ld_ready, 1);
                    check({nm, "_cfg_error_t1"}, cfg_error, 0);
                end
            end
            if (glb_write_en && glb_read_req) both++;
            if (ld_ready) load_cyc++;
            if (busy && !ld_ready) disp_cyc++;
            if (ld_valid && ld_ready) begin
                if (!glb_write_en || glb_w_addr != AW'(li) ||
                    glb_w_data != ld_words[li]) wr_bad++;
                last_hs = cyc;
                li++;
            end else if (glb_write_en) begin
                wr_bad++;
            end
            if (glb_read_req) begin
                reads++;
                if (first_rd < 0) first_rd = cyc;
            end
            if (stall) begin
                if (!wt_valid || wt_data != st_d || wt_last_filt != st_lf ||
                    wt_last != st_ls) stall_bad++;
            end
            if (wt_valid && wt_ready) begin
                if (oi >= exp_q.size()) out_bad++;
                else if (wt_data != exp_q[oi] || wt_last_filt != lf_q[oi] ||
                         wt_last != ls_q[oi]) out_bad++;
                oi++;
            end
            stall = wt_valid && !wt_ready;
            st_d  = wt_data;
            st_lf = wt_last_filt;
            st_ls = wt_last;
            if (reads - oi > 2) over++;
            if (done) begin
                dones++;
                break;
            end
            if (abort_pops >= 0 && oi == abort_pops) begin
                start = 1'b0;
                return;
            end
        end
        start = 1'b0;

        check({nm, "_timeout"}, (cyc <= bound), 1);
        check({nm, "_done_pulses"}, dones, 1);
        check({nm, "_words_out"}, oi, exp_words);
        check({nm, "_out_mismatch"}, out_bad, 0);
        check({nm, "_writes"}, li, exp_err ? 0 : n);
        check({nm, "_write_bad"}, wr_bad, 0);
        check({nm, "_reads"}, reads, exp_words);
        check({nm, "_both_strobes"}, both, 0);
        check({nm, "_outstanding"}, over, 0);
        check({nm, "_stall_stable"}, stall_bad, 0);
        if (!exp_err) begin
            check({nm, "_first_read"}, first_rd, last_hs + 1);
            if (vld_pct == 100) check({nm, "_load_len"}, load_cyc, n);
            if (rdy_pct == 100)
                check({nm, "_dispatch_len"}, disp_cyc, exp_words + 2);
        end
    endtask

    initial begin
        tbl[0]  = '{2, 3, 1, 100, 100, 1, 0, 0, 6};
        tbl[1]  = '{2, 3, 3, 100, 100, 1, 0, 0, 18};
        tbl[2]  = '{2, 3, 2, 50, 60, 0, 0, 0, 12};
        tbl[3]  = '{2, 0, 1, 100, 100, 0, 0, 1, 0};
        tbl[4]  = '{64, 32, 1, 100, 100, 0, 0, 1, 0};
        tbl[5]  = '{3, 4, 2, 100, 100, 0, 1, 0, 24};
        tbl[6]  = '{4, 5, 2, 50, 70, 0, 0, 0, 40};
        tbl[7]  = '{32, 32, 1, 100, 100, 0, 0, 0, 1024};
        tbl[8]  = '{1, 1, 1, 100, 100, 0, 0, 0, 1};
        tbl[9]  = '{0, 5, 1, 100, 100, 0, 0, 1, 0};
        tbl[10] = '{3, 2, 0, 100, 100, 0, 0, 1, 0};
        tbl[11] = '{5, 3, 3, 30, 40, 0, 1, 0, 45};

        reset = 1'b1;
        start = 1'b0;
        cfg_num_filters = '0;
        cfg_filt_size   = '0;
        cfg_num_passes  = '0;
        ld_valid = 1'b0;
        ld_data  = '0;
        wt_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        reset = 1'b0;

        for (int v = 0; v < 12; v++) begin
            ld_words.delete();
            if (!tbl[v].exp_err)
                for (int i = 0; i < tbl[v].f * tbl[v].k; i++)
                    ld_words.push_back(tbl[v].seq ? DW'(i + 1) : DW'($urandom));
            run_job($sformatf("vec%0d", v), tbl[v].f, tbl[v].k, tbl[v].p,
                    tbl[v].rdy_pct, tbl[v].vld_pct, tbl[v].poke,
                    tbl[v].exp_err, tbl[v].exp_words, -1);
        end

        // Reset while dispatching, after the third word is accepted.
        ld_words.delete();
        for (int i = 0; i < 6; i++) ld_words.push_back(DW'(i + 1));
        run_job("abort", 2, 3, 1, 100, 100, 0, 0, 6, 3);
        reset = 1'b1;
        ld_valid = 1'b0;
        @(negedge clk);
        #1;
        check_reset_outputs("midrst");
        reset = 1'b0;

        ld_words.delete();
        ld_words.push_back(DW'(7));
        ld_words.push_back(DW'(8));
        run_job("post_rst", 1, 2, 1, 100, 100, 0, 0, 2, -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
